// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEF_ADDR_W    default PC / memory address width
//   DEF_RESET_PC  default byte address of the first fetch after reset
//   DEF_PC_STEP   default byte increment between sequential fetches
//   FIFO_DEPTH    number of fetched words the output buffer can hold
//   ST_*          fetch FSM state encodings
package inst_fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP  = 4;
    localparam int unsigned FIFO_DEPTH   = 2;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/inst_fetch_skid_fifo.sv
// Two-entry buffer between the BRAM return path and the decoder.
// The head entry always sits in slot0, so the head output comes straight from a register.
//   clk        clock
//   rst        asynchronous, active-high reset
//   clear      drop all entries (wins over push and pop)
//   push       write push_data (never issued while full without a pop)
//   push_data  entry to store
//   pop        remove the head entry (only while count != 0)
//   count      number of stored entries (0..2)
//   head       oldest entry, undefined content while count == 0
module inst_fetch_skid_fifo #(
    parameter int unsigned WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (clear) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = push_data;
                    end else begin
                        slot1_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        slot0_d = push_data;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous BRAM with 1-cycle read latency
// and hands {instruction, pc, pc+step} to the decoder over a valid/ready handshake.
//   clk              fetch clock
//   RST              asynchronous, active-high reset
//   imem_ena         BRAM read request this cycle
//   imem_addr        BRAM byte address
//   imem_rdata       BRAM read data, valid the cycle after imem_ena
//   redirect_valid   taken branch/jump this cycle
//   redirect_target  new PC, low two bits ignored
//   inst_valid       inst_out / inst_pc / inst_pc_plus4 hold a fetched word
//   inst_ready       consumer accepts the presented word
//   inst_out         instruction word
//   inst_pc          byte address of inst_out
//   inst_pc_plus4    inst_pc + PC_STEP
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned       PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              RST,
    output logic              imem_ena,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus4
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam int unsigned       ENTRY_W    = 32 + 2 * ADDR_W;
    localparam logic [1:0]        FULL_COUNT = 2'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc_req_q, pc_req_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_epoch_q, inflight_epoch_d;
    logic              epoch_q, epoch_d;
    fetch_state_t      state_q, state_d;

    logic [1:0]         count;
    logic               full;
    logic               push;
    logic               pop;
    logic [1:0]         pending;
    logic               credit_ok;
    logic               issue;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;

    assign full       = (count == FULL_COUNT);
    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & inst_ready;
    // Words from before the last redirect belong to the old epoch and are dropped.
    assign push       = inflight_q & (inflight_epoch_q == epoch_q);
    assign push_data  = {imem_rdata, inflight_pc_q, inflight_pc_q + STEP};

    // A pop this cycle frees its slot in time for the word returning next cycle.
    assign pending   = (count - {1'b0, pop}) + {1'b0, inflight_q};
    assign credit_ok = (pending < FULL_COUNT);

    always_comb begin
        issue = 1'b0;
        if (!RST && !redirect_valid) begin
            // HOLD only occurs with a full buffer and nothing in flight.
            if (state_q == ST_HOLD) begin
                issue = pop;
            end else begin
                issue = credit_ok;
            end
        end
    end

    always_comb begin
        pc_req_d         = pc_req_q;
        inflight_d       = issue;
        inflight_pc_d    = inflight_pc_q;
        inflight_epoch_d = inflight_epoch_q;
        epoch_d          = epoch_q;
        if (redirect_valid) begin
            pc_req_d = redirect_target & ALIGN_MASK;
            epoch_d  = ~epoch_q;
        end else if (issue) begin
            pc_req_d         = pc_req_q + STEP;
            inflight_pc_d    = pc_req_q;
            inflight_epoch_d = epoch_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                default: state_d = (full && !inst_ready) ? ST_HOLD : ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pc_req_q         <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
            state_q          <= ST_IDLE;
        end else begin
            pc_req_q         <= pc_req_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_epoch_q <= inflight_epoch_d;
            epoch_q          <= epoch_d;
            state_q          <= state_d;
        end
    end

    inst_fetch_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (RST),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign imem_ena  = issue;
    assign imem_addr = pc_req_q;
    assign {inst_out, inst_pc, inst_pc_plus4} = head;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a stream-level model of the fetch stage.
module tb_inst_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_ena;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    logic        rst1;
    logic        ena1;
    logic [31:0] addr1;
    logic [31:0] rdata1 = 32'h0;
    logic        wrap_redirect = 1'b0;
    logic [31:0] wrap_target = 32'h0;
    logic        valid1;
    logic        wrap_ready = 1'b1;
    logic [31:0] out1;
    logic [31:0] pc1;
    logic [31:0] pc41;

    int errors = 0;
    int checks = 0;

    inst_fetch dut (
        .clk             (clk),
        .RST             (rst),
        .imem_ena        (imem_ena),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .inst_pc_plus4   (inst_pc_plus4)
    );

    inst_fetch #(
        .RESET_PC (WRAP_PC)
    ) dut_wrap (
        .clk             (clk),
        .RST             (rst1),
        .imem_ena        (ena1),
        .imem_addr       (addr1),
        .imem_rdata      (rdata1),
        .redirect_valid  (wrap_redirect),
        .redirect_target (wrap_target),
        .inst_valid      (valid1),
        .inst_ready      (wrap_ready),
        .inst_out        (out1),
        .inst_pc         (pc1),
        .inst_pc_plus4   (pc41)
    );

    // BRAM contents: word i holds the value i.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        if (imem_ena) imem_rdata <= word_of(imem_addr);
        if (ena1) rdata1 <= word_of(addr1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream-level model: the presented words must be the consecutive PCs of the current stream,
    // restarting at RESET_PC on reset and at the aligned target on redirect.
    logic [31:0] exp_pc;
    int          cyc;
    int          since_redir;
    int          quiet;
    int          stall;
    logic        held;

    initial begin
        exp_pc = 32'h0; cyc = 0; since_redir = 100; quiet = 0; stall = 0; held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ena", {31'b0, imem_ena}, 32'h0);
                chk("rst_addr", imem_addr, 32'h0);
                chk("rst_valid", {31'b0, inst_valid}, 32'h0);
                chk("rst_out", inst_out, 32'h0);
                chk("rst_pc", inst_pc, 32'h0);
                chk("rst_pc4", inst_pc_plus4, 32'h0);
                exp_pc = 32'h0; cyc = 0; since_redir = 100; quiet = 0; stall = 0; held = 1'b0;
            end else begin
                if (redirect_valid) chk("redir_no_issue", {31'b0, imem_ena}, 32'h0);
                if (imem_ena) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
                if (cyc < 2 || since_redir <= 1) chk("valid_low", {31'b0, inst_valid}, 32'h0);
                if (quiet >= 2 || held) chk("valid_high", {31'b0, inst_valid}, 32'h1);
                if (stall >= 3 && !inst_ready && !redirect_valid)
                    chk("stall_no_issue", {31'b0, imem_ena}, 32'h0);
                if (inst_valid) begin
                    chk("stream_pc", inst_pc, exp_pc);
                    chk("stream_inst", inst_out, word_of(exp_pc));
                    chk("stream_pc4", inst_pc_plus4, exp_pc + 32'd4);
                end
                held = inst_valid && !inst_ready && !redirect_valid;
                if (redirect_valid) exp_pc = redirect_target & ~32'h3;
                else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
                if (cyc < 1000) cyc++;
                since_redir = redirect_valid ? 0 : ((since_redir < 100) ? since_redir + 1 : 100);
                quiet = (!redirect_valid && inst_ready) ? quiet + 1 : 0;
                stall = (!redirect_valid && !inst_ready) ? stall + 1 : 0;
            end
        end
    end

    // Leaves the bench at posedge+2 of cycle C0 after release.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic found;
        rst = 1'b1; rst1 = 1'b1;
        redirect_valid = 1'b0; redirect_target = 32'h0; inst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst1 = 1'b0;
        #1;
        // Reset release: first issue in C0, first word in C2
        chk("c0_ena", {31'b0, imem_ena}, 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();                                     // C1
        chk("c1_valid", {31'b0, inst_valid}, 32'h0);
        tick();                                     // C2
        chk("c2_valid", {31'b0, inst_valid}, 32'h1);
        chk("c2_pc", inst_pc, 32'h0);
        chk("c2_inst", inst_out, 32'h0);
        chk("c2_pc4", inst_pc_plus4, 32'h4);
        chk("wrap_c2_pc", pc1, 32'hFFFF_FFF8);
        chk("wrap_c2_inst", out1, 32'h3FFF_FFFE);
        tick();                                     // C3
        chk("c3_pc", inst_pc, 32'h4);
        chk("c3_inst", inst_out, 32'h1);
        chk("wrap_c3_pc", pc1, 32'hFFFF_FFFC);
        chk("wrap_c3_pc4", pc41, 32'h0);
        tick();                                     // C4
        chk("c4_pc", inst_pc, 32'h8);
        chk("c4_inst", inst_out, 32'h2);
        chk("wrap_c4_pc", pc1, 32'h0);
        chk("wrap_c4_inst", out1, 32'h0);

        // Backpressure: hold pc 8 for five cycles, then drain without gap or duplicate
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {31'b0, inst_valid}, 32'h1);
            chk("bp_hold_pc", inst_pc, 32'h8);
            if (i == 4) chk("bp_no_issue", {31'b0, imem_ena}, 32'h0);
            tick();
        end
        inst_ready = 1'b1;
        chk("bp_resume_pc0", inst_pc, 32'h8);
        tick();
        chk("bp_resume_pc1", inst_pc, 32'hC);
        tick();
        chk("bp_resume_pc2", inst_pc, 32'h10);
        chk("bp_resume_valid", {31'b0, inst_valid}, 32'h1);

        // Redirect to 0x40 while 0x10 is in flight
        tick();
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_ena && imem_addr == 32'h10) found = 1'b1;
            else tick();
        end
        chk("find_issue_0x10", {31'b0, found}, 32'h1);
        tick();                                     // R
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();                                     // R+1
        redirect_valid = 1'b0;
        chk("r1_valid", {31'b0, inst_valid}, 32'h0);
        tick();                                     // R+2
        chk("r2_valid", {31'b0, inst_valid}, 32'h0);
        tick();                                     // R+3
        chk("r3_valid", {31'b0, inst_valid}, 32'h1);
        chk("r3_pc", inst_pc, 32'h40);
        chk("r3_inst", inst_out, 32'h10);

        // Unaligned target, then back-to-back redirects
        redirect_valid = 1'b1; redirect_target = 32'h43;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("unaligned_pc", inst_pc, 32'h40);
        redirect_valid = 1'b1; redirect_target = 32'h80;
        tick();
        redirect_target = 32'hC0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("b2b_valid", {31'b0, inst_valid}, 32'h1);
        chk("b2b_pc", inst_pc, 32'hC0);
        tick();
        chk("b2b_next_pc", inst_pc, 32'hC4);

        // Asynchronous reset mid-stream
        tick();
        chk("pre_rst_valid", {31'b0, inst_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("async_rst_ena", {31'b0, imem_ena}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;                                 // C0
        tick();
        tick();                                     // C2
        chk("restart_valid", {31'b0, inst_valid}, 32'h1);
        chk("restart_pc", inst_pc, 32'h0);

        // Randomized phase, checked by the stream model
        begin
            int rst_left;
            int ready_pct;
            rst_left = 0;
            ready_pct = 80;
            for (int i = 0; i < 1200; i++) begin
                tick();
                if (i % 100 == 0) ready_pct = (ready_pct == 80) ? 15 : 80;
                if (rst_left > 0) begin
                    rst_left--;
                    if (rst_left == 0) rst = 1'b0;
                end else if ($urandom_range(0, 299) == 0) begin
                    rst = 1'b1;
                    rst_left = 2;
                end
                inst_ready = ($urandom_range(0, 99) < ready_pct);
                redirect_valid = !rst && ($urandom_range(0, 99) < 5);
                redirect_target = $urandom;
            end
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
